// File: rtl/looper_cmt_pkg.sv
// Shared types for the looper retirement path: head-slot geometry, FSM states,
// and a small popcount helper for commit masks.
package looper_cmt_pkg;

    localparam int unsigned NUM_SLOTS  = 4;
    localparam int unsigned SLOT_IDX_W = 2;
    localparam int unsigned CMT_CNT_W  = 3;

    typedef logic [SLOT_IDX_W-1:0] slot_idx_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } cmt_state_e;

    function automatic logic [CMT_CNT_W-1:0] popcnt_slots(input logic [NUM_SLOTS-1:0] m);
        logic [CMT_CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            c = c + CMT_CNT_W'(m[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/cmt_slot_select.sv
// Picks the contiguous in-order commit group from the head slots, honouring the
// single store port and stopping after the first mispredicted branch.
module cmt_slot_select
    import looper_cmt_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] vld_i,
    input  logic [NUM_SLOTS-1:0] done_i,
    input  logic [NUM_SLOTS-1:0] st_i,
    input  logic [NUM_SLOTS-1:0] mispred_i,
    input  logic                 st_rdy_i,
    output logic [NUM_SLOTS-1:0] mask_o,
    output logic                 st_hit_o,
    output slot_idx_t            st_slot_o,
    output logic                 mp_hit_o,
    output slot_idx_t            mp_slot_o
);

    logic go;
    logic st_seen;

    // Walk oldest to youngest; the first blocked slot closes the group.
    always_comb begin
        mask_o    = '0;
        st_hit_o  = 1'b0;
        st_slot_o = '0;
        mp_hit_o  = 1'b0;
        mp_slot_o = '0;
        go        = 1'b1;
        st_seen   = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (go) begin
                if (vld_i[i] && done_i[i] && !(st_i[i] && (!st_rdy_i || st_seen))) begin
                    mask_o[i] = 1'b1;
                    if (st_i[i]) begin
                        st_seen   = 1'b1;
                        st_hit_o  = 1'b1;
                        st_slot_o = SLOT_IDX_W'(i);
                    end
                    if (mispred_i[i]) begin
                        mp_hit_o  = 1'b1;
                        mp_slot_o = SLOT_IDX_W'(i);
                        go        = 1'b0;
                    end
                end else begin
                    go = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/commit_scheduler.sv
// Retirement controller: gates the selected commit group, drives store and
// register-write enables, and sequences flush/redirect after mispredicts or PC loads.
module commit_scheduler
    import looper_cmt_pkg::*;
#(
    parameter int unsigned PC_W      = 16,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SLOTS-1:0]      hd_vld,
    input  logic [NUM_SLOTS-1:0]      hd_done,
    input  logic [NUM_SLOTS-1:0]      hd_reg_wrt,
    input  logic [NUM_SLOTS-1:0]      hd_st,
    input  logic [NUM_SLOTS-1:0]      hd_mispred,
    input  logic [NUM_SLOTS*PC_W-1:0] hd_rcvr_pc,
    input  logic                      st_rdy,
    input  logic                      extern_pc_en,
    input  logic [PC_W-1:0]           extern_pc,
    output logic [NUM_SLOTS-1:0]      cmt_vld,
    output logic [CMT_CNT_W-1:0]      cmt_cnt,
    output logic [NUM_SLOTS-1:0]      reg_wrt_en,
    output logic                      st_en,
    output logic [SLOT_IDX_W-1:0]     st_slot,
    output logic                      flush,
    output logic                      redirect_en,
    output logic [PC_W-1:0]           redirect_pc,
    output logic                      busy,
    output logic [CNT_W-1:0]          ret_total
);

    localparam int unsigned FC_W = $clog2(FLUSH_CYC + 1);
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYC);
    localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

    cmt_state_e          state_q, state_d;
    logic [FC_W-1:0]     fcnt_q, fcnt_d;
    logic                flush_q, flush_d;
    logic [PC_W-1:0]     redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]    ret_total_q, ret_total_d;

    logic [NUM_SLOTS-1:0] sel_mask;
    logic                 sel_st_hit;
    slot_idx_t            sel_st_slot;
    logic                 sel_mp_hit;
    slot_idx_t            sel_mp_slot;
    logic                 run_ok;
    logic                 mp_commit;
    logic [PC_W-1:0]      rcvr_pc [NUM_SLOTS];

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_rcvr
        assign rcvr_pc[g] = hd_rcvr_pc[g*PC_W +: PC_W];
    end

    cmt_slot_select u_sel (
        .vld_i     (hd_vld),
        .done_i    (hd_done),
        .st_i      (hd_st),
        .mispred_i (hd_mispred),
        .st_rdy_i  (st_rdy),
        .mask_o    (sel_mask),
        .st_hit_o  (sel_st_hit),
        .st_slot_o (sel_st_slot),
        .mp_hit_o  (sel_mp_hit),
        .mp_slot_o (sel_mp_slot)
    );

    // A PC load squashes this cycle's group, including any mispredict in it.
    assign run_ok     = !rst && !extern_pc_en && (state_q == ST_RUN);
    assign cmt_vld    = run_ok ? sel_mask : '0;
    assign cmt_cnt    = popcnt_slots(cmt_vld);
    assign reg_wrt_en = cmt_vld & hd_reg_wrt;
    assign st_en      = run_ok && sel_st_hit;
    assign st_slot    = st_en ? sel_st_slot : '0;
    assign mp_commit  = run_ok && sel_mp_hit;

    assign flush       = flush_q;
    assign redirect_en = flush_q;
    assign redirect_pc = redirect_pc_q;
    assign busy        = (state_q == ST_FLUSH);
    assign ret_total   = ret_total_q;

    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        flush_d       = 1'b0;
        redirect_pc_d = redirect_pc_q;
        ret_total_d   = ret_total_q + CNT_W'(cmt_cnt);
        if (extern_pc_en) begin
            state_d       = ST_FLUSH;
            fcnt_d        = FC_LOAD;
            flush_d       = 1'b1;
            redirect_pc_d = extern_pc;
        end else if (mp_commit) begin
            state_d       = ST_FLUSH;
            fcnt_d        = FC_LOAD;
            flush_d       = 1'b1;
            redirect_pc_d = rcvr_pc[sel_mp_slot];
        end else if (state_q == ST_FLUSH) begin
            // The pulse cycle is the first of the FLUSH_CYC blocked cycles.
            if (fcnt_q == FC_ONE) begin
                state_d = ST_RUN;
                fcnt_d  = '0;
            end else begin
                fcnt_d = fcnt_q - FC_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            fcnt_q        <= '0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            ret_total_q   <= '0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            flush_q       <= flush_d;
            redirect_pc_q <= redirect_pc_d;
            ret_total_q   <= ret_total_d;
        end
    end

endmodule

// File: tb/tb_commit_scheduler.sv
// Self-checking bench for commit_scheduler: vector table through a scoreboard
// queue, then hand sequences for flush, PC load, reset-in-flush and counter wrap.
module tb_commit_scheduler;

    localparam int unsigned PC_W      = 16;
    localparam int unsigned FLUSH_CYC = 2;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned NVEC      = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        hd_vld, hd_done, hd_reg_wrt, hd_st, hd_mispred;
    logic [4*PC_W-1:0] hd_rcvr_pc;
    logic              st_rdy;
    logic              extern_pc_en;
    logic [PC_W-1:0]   extern_pc;
    logic [3:0]        cmt_vld;
    logic [2:0]        cmt_cnt;
    logic [3:0]        reg_wrt_en;
    logic              st_en;
    logic [1:0]        st_slot;
    logic              flush;
    logic              redirect_en;
    logic [PC_W-1:0]   redirect_pc;
    logic              busy;
    logic [CNT_W-1:0]  ret_total;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] done;
        logic [3:0] rw;
        logic [3:0] st;
        logic       rdy;
        logic [3:0] exp_vld;
        logic       exp_st_en;
        logic [1:0] exp_st_slot;
    } vec_t;

    vec_t             tbl [NVEC];
    vec_t             sb_q [$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_total;

    always #5 clk = ~clk;

    commit_scheduler #(
        .PC_W      (PC_W),
        .FLUSH_CYC (FLUSH_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hd_vld       (hd_vld),
        .hd_done      (hd_done),
        .hd_reg_wrt   (hd_reg_wrt),
        .hd_st        (hd_st),
        .hd_mispred   (hd_mispred),
        .hd_rcvr_pc   (hd_rcvr_pc),
        .st_rdy       (st_rdy),
        .extern_pc_en (extern_pc_en),
        .extern_pc    (extern_pc),
        .cmt_vld      (cmt_vld),
        .cmt_cnt      (cmt_cnt),
        .reg_wrt_en   (reg_wrt_en),
        .st_en        (st_en),
        .st_slot      (st_slot),
        .flush        (flush),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .busy         (busy),
        .ret_total    (ret_total)
    );

    function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] done,
                                input logic [3:0] rw, input logic [3:0] st, input logic rdy,
                                input logic [3:0] ev, input logic es, input logic [1:0] esl);
        vec_t v;
        v.vld = vld; v.done = done; v.rw = rw; v.st = st; v.rdy = rdy;
        v.exp_vld = ev; v.exp_st_en = es; v.exp_st_slot = esl;
        return v;
    endfunction

    function automatic logic [2:0] ones(input logic [3:0] m);
        logic [2:0] n;
        n = 3'd0;
        if (m[0]) n = n + 3'd1;
        if (m[1]) n = n + 3'd1;
        if (m[2]) n = n + 3'd1;
        if (m[3]) n = n + 3'd1;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] vld, input logic [3:0] done, input logic [3:0] rw,
                         input logic [3:0] st, input logic [3:0] mp, input logic rdy,
                         input logic ext_en, input logic [PC_W-1:0] ext_pc);
        hd_vld = vld; hd_done = done; hd_reg_wrt = rw; hd_st = st; hd_mispred = mp;
        st_rdy = rdy; extern_pc_en = ext_en; extern_pc = ext_pc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t e;
        tbl[0]  = mk(4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b1111, 1'b0, 2'd0);
        tbl[1]  = mk(4'b1111, 4'b1011, 4'b0000, 4'b0000, 1'b1, 4'b0011, 1'b0, 2'd0);
        tbl[2]  = mk(4'b1111, 4'b1111, 4'b0000, 4'b0110, 1'b1, 4'b0011, 1'b1, 2'd1);
        tbl[3]  = mk(4'b1111, 4'b1111, 4'b0000, 4'b0110, 1'b0, 4'b0001, 1'b0, 2'd0);
        tbl[4]  = mk(4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);
        tbl[5]  = mk(4'b0111, 4'b1111, 4'b0110, 4'b0000, 1'b1, 4'b0111, 1'b0, 2'd0);
        tbl[6]  = mk(4'b1111, 4'b1110, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);
        tbl[7]  = mk(4'b1111, 4'b1111, 4'b0000, 4'b1000, 1'b1, 4'b1111, 1'b1, 2'd3);
        tbl[8]  = mk(4'b1111, 4'b1111, 4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0);
        tbl[9]  = mk(4'b1111, 4'b1111, 4'b0101, 4'b0000, 1'b1, 4'b1111, 1'b0, 2'd0);
        tbl[10] = mk(4'b1101, 4'b1111, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0);

        hd_rcvr_pc = {16'h3333, 16'h2222, 16'h0040, 16'h1111};

        // Reset with a fully ready head: combinational outputs must stay quiet.
        rst = 1'b1;
        drive(4'b1111, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmt_vld", 32'(cmt_vld), 32'h0);
        chk("rst_st_en", 32'(st_en), 32'h0);
        chk("rst_reg_wrt", 32'(reg_wrt_en), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_redir_en", 32'(redirect_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_redir_pc", 32'(redirect_pc), 32'h0);
        chk("rst_ret_total", ret_total, 32'h0);
        exp_total = '0;
        next_cycle();
        rst = 1'b0;

        // Table vectors in RUN state, pushed to the scoreboard as driven.
        for (int i = 0; i < int'(NVEC); i++) begin
            if (i != 0) next_cycle();
            drive(tbl[i].vld, tbl[i].done, tbl[i].rw, tbl[i].st, 4'b0000, tbl[i].rdy, 1'b0, '0);
            sb_q.push_back(tbl[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            chk($sformatf("v%0d_cmt_vld", i), 32'(cmt_vld), 32'(e.exp_vld));
            chk($sformatf("v%0d_cmt_cnt", i), 32'(cmt_cnt), 32'(ones(e.exp_vld)));
            chk($sformatf("v%0d_reg_wrt", i), 32'(reg_wrt_en), 32'(e.exp_vld & e.rw));
            chk($sformatf("v%0d_st_en", i), 32'(st_en), 32'(e.exp_st_en));
            chk($sformatf("v%0d_st_slot", i), 32'(st_slot), 32'(e.exp_st_slot));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'h0);
            chk($sformatf("v%0d_ret_total", i), ret_total, exp_total);
            exp_total = exp_total + CNT_W'(ones(e.exp_vld));
        end

        // Committed mispredict in slot 1, then FLUSH_CYC blocked cycles.
        next_cycle();
        drive(4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("mp_cmt_vld", 32'(cmt_vld), 32'h3);
        chk("mp_cmt_cnt", 32'(cmt_cnt), 32'h2);
        chk("mp_flush_early", 32'(flush), 32'h0);
        exp_total = exp_total + 2;
        next_cycle();
        drive(4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("mp_flush", 32'(flush), 32'h1);
        chk("mp_redir_en", 32'(redirect_en), 32'h1);
        chk("mp_redir_pc", 32'(redirect_pc), 32'h0040);
        chk("mp_busy1", 32'(busy), 32'h1);
        chk("mp_blk1", 32'(cmt_vld), 32'h0);
        chk("mp_ret_total", ret_total, exp_total);
        next_cycle();
        @(negedge clk);
        chk("mp_flush_drop", 32'(flush), 32'h0);
        chk("mp_busy2", 32'(busy), 32'h1);
        chk("mp_blk2", 32'(cmt_vld), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("mp_run_busy", 32'(busy), 32'h0);
        chk("mp_run_cmt", 32'(cmt_vld), 32'hf);
        chk("mp_run_total", ret_total, exp_total);
        exp_total = exp_total + 4;

        // PC load beats a same-cycle mispredict, then restarts the window from FLUSH.
        next_cycle();
        drive(4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b1, 16'h1234);
        @(negedge clk);
        chk("ext_cmt_vld", 32'(cmt_vld), 32'h0);
        chk("ext_cmt_cnt", 32'(cmt_cnt), 32'h0);
        chk("ext_total", ret_total, exp_total);
        next_cycle();
        drive(4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 16'h5678);
        @(negedge clk);
        chk("ext_flush", 32'(flush), 32'h1);
        chk("ext_redir_pc", 32'(redirect_pc), 32'h1234);
        chk("ext_busy", 32'(busy), 32'h1);
        chk("ext_total_hold", ret_total, exp_total);
        next_cycle();
        drive(4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("ext2_flush", 32'(flush), 32'h1);
        chk("ext2_redir_pc", 32'(redirect_pc), 32'h5678);
        chk("ext2_busy", 32'(busy), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("ext2_flush_drop", 32'(flush), 32'h0);
        chk("ext2_busy2", 32'(busy), 32'h1);
        next_cycle();
        @(negedge clk);
        chk("ext2_run_busy", 32'(busy), 32'h0);
        chk("ext2_run_cmt", 32'(cmt_vld), 32'hf);
        chk("ext2_total", ret_total, exp_total);
        exp_total = exp_total + 4;

        // Reset during the flush pulse drops the pending window and the counter.
        next_cycle();
        drive(4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("rf_cmt_vld", 32'(cmt_vld), 32'h1);
        next_cycle();
        rst = 1'b1;
        drive(4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("rf_pulse", 32'(flush), 32'h1);
        chk("rf_redir_pc", 32'(redirect_pc), 32'h1111);
        chk("rf_rst_cmt", 32'(cmt_vld), 32'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rf_busy", 32'(busy), 32'h0);
        chk("rf_flush", 32'(flush), 32'h0);
        chk("rf_redir_en", 32'(redirect_en), 32'h0);
        chk("rf_redir_pc0", 32'(redirect_pc), 32'h0);
        chk("rf_total", ret_total, 32'h0);
        chk("rf_run_cmt", 32'(cmt_vld), 32'hf);
        exp_total = 32'd4;

        // Counter wraps silently past 2^32-1.
        next_cycle();
        @(negedge clk);
        chk("wrap_pre", ret_total, exp_total);
        force dut.ret_total_q = 32'hFFFF_FFFE;
        #1;
        release dut.ret_total_q;
        next_cycle();
        drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("wrap_total", ret_total, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
